// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   Sequential multiply/divide engine that owns the architectural HI/LO
//   registers. The EX stage issues an operation with a one-cycle start pulse
//   and stalls while busy is high. One radix-2 step is taken per cycle:
//   shift-add for multiply, restoring division for divide. Signed operations
//   run on magnitudes and are sign-corrected in a final FIX cycle.
//
//   Optional feature: define MULDIV_EARLY_OUT_EN to let a multiply leave CALC
//   as soon as the remaining multiplier bits are all zero.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : one-cycle operation request, sampled only in IDLE
//   op     : 00 multu, 01 mult, 10 divu, 11 div
//   src_a  : multiplicand / dividend
//   src_b  : multiplier / divisor
//   flush  : abort the in-flight operation, no done, hi/lo untouched
//   hi_we  : mthi write enable (IDLE only)
//   lo_we  : mtlo write enable (IDLE only)
//   wdata  : mthi/mtlo data
//   busy   : high while an operation is in flight
//   done   : one-cycle pulse; hi/lo hold the new result in that cycle
//   hi     : HI register (product high word / remainder)
//   lo     : LO register (product low word / quotient)
module muldiv_hilo_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {upper accumulator, remaining multiplier}.
    // Divide:   {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd_b;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               sign_res;   // negate product / quotient in FIX
    logic               sign_rem;   // negate remainder in FIX

    logic               accept;
    logic               last_iter;
    logic               early_out;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               b_zero;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   trial;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] acc_calc;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    logic [WIDTH-1:0]   live_mask;
    logic [CNT_W:0]     shamt;
`endif

    assign accept    = (state == S_IDLE) && start && !flush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != S_IDLE);

    // Operand magnitudes for the signed variants.
    always_comb begin
        a_mag  = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
        b_mag  = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;
        b_zero = (src_b == '0);
    end

    // One radix-2 iteration of each datapath.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd_b} : '0);
        mul_step = {mul_sum, acc[WIDTH-1:1]};

        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial  = rem_sh[WIDTH-1:0] - opd_b;
        if (rem_sh >= {1'b0, opd_b}) begin
            div_step = {trial, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end

        acc_calc  = is_div ? div_step : mul_step;
        early_out = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        // After cnt iterations the unconsumed multiplier bits sit in the low
        // WIDTH-cnt bits. If they are all zero, the remaining iterations would
        // only shift, so do the whole shift at once.
        live_mask = ONES >> cnt;
        shamt     = (CNT_W + 1)'(WIDTH) - {1'b0, cnt};
        if (!is_div && ((acc[WIDTH-1:0] & live_mask) == '0)) begin
            early_out = 1'b1;
            acc_calc  = acc >> shamt;
        end
`endif
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = sign_res ? -acc : acc;
        quo_fix  = sign_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_CALC;
            S_CALC: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (last_iter || early_out) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opd_b    <= '0;
            is_div   <= 1'b0;
            sign_res <= 1'b0;
            sign_rem <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            opd_b <= b_mag;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            opd_b <= a_mag;
                        end
                        // Divide by zero suppresses the quotient negation so lo
                        // stays all ones; the remainder keeps the dividend sign,
                        // which restores src_a exactly into hi.
                        sign_res <= op[0] && (src_a[WIDTH-1] ^ src_b[WIDTH-1])
                                    && !(op[1] && b_zero);
                        sign_rem <= op[0] && op[1] && src_a[WIDTH-1];
                    end else if (!start) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= acc_calc;
                end
                S_FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Testbench for muldiv_hilo_unit: directed cases plus randomized operations,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];

    muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb_;
        longint q;
        longint r;
        logic [63:0] q64;
        logic [63:0] r64;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (o)
            2'b00: return {32'd0, a} * {32'd0, b};
            2'b01: return 64'(sa * sb_);
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q   = sa / sb_;
                r   = sa % sb_;
                q64 = 64'(q);
                r64 = 64'(r);
                return {r64[31:0], q64[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Called at posedge+1; start is sampled at the next edge (cycle 0 of the
    // operation), done is due 34 cycles after that.
    task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] e, input bit push);
        exp_t x;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (push) begin
            x.hi  = e[63:32];
            x.lo  = e[31:0];
            x.due = cyc + 34;
            sb.push_back(x);
        end
        wait_cyc(1);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e);
        drive_start(o, a, b, e, 1'b1);
        wait_cyc(35);
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending result", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {hi, lo}, {e.hi, e.lo});
`ifdef MULDIV_EARLY_OUT_EN
                    check("latency_max", 64'(cyc > e.due), 64'd0);
`else
                    check("latency", 64'(cyc), 64'(e.due));
`endif
                end
            end
        end
    end

    initial begin
        int bad_busy;
        int saw_done;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        wdata = '0;

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        wait_cyc(2);

        // multu all-ones with busy window 1..33, idle again at 34.
        drive_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        bad_busy = 0;
        for (int i = 1; i <= 33; i++) begin
            if (busy !== 1'b1) bad_busy++;
            wait_cyc(1);
        end
        check("busy_window_low_cycles", 64'(bad_busy), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        wait_cyc(2);

        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'h8000_0005, 32'h0000_0000, 64'h8000_0005_FFFF_FFFF);
        run_op(2'b00, 32'h0000_0007, 32'h0000_0003, 64'h0000_0000_0000_0015);

        // mthi/mtlo.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        wait_cyc(1);
        check("dual_write", {hi, lo}, 64'h1234_5678_1234_5678);
        lo_we = 1'b0;
        wdata = 32'hAAAA_0000;
        wait_cyc(1);
        hi_we = 1'b0;
        check("mthi", {hi, lo}, 64'hAAAA_0000_1234_5678);

        // Flush at cycle 10 of a multu.
        drive_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0);
        wait_cyc(9);
        flush = 1'b1;
        wait_cyc(1);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done++;
            wait_cyc(1);
        end
        check("flush_no_done", 64'(saw_done), 64'd0);
        check("flush_hi_kept", 64'(hi), 64'h0000_0000_AAAA_0000);

        // start together with hi_we: start wins, write dropped.
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        drive_start(2'b00, 32'd2, 32'd3, 64'd6, 1'b1);
        hi_we = 1'b0;
        check("start_wins_over_mthi", 64'(hi), 64'h0000_0000_AAAA_0000);
        wait_cyc(35);

        // hi_we/lo_we while busy are ignored.
        drive_start(2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
        wait_cyc(2);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1111_1111;
        wait_cyc(1);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_while_busy", {hi, lo}, 64'h0000_0000_0000_0006);
        wait_cyc(33);

        // Back-to-back: second start in the done cycle.
        drive_start(2'b01, 32'd12, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFE8, 1'b1);
        wait_cyc(33);
        drive_start(2'b10, 32'd1000, 32'd9, {32'd1, 32'd111}, 1'b1);
        wait_cyc(35);

        // Start at cycle 5 while busy is ignored.
        drive_start(2'b10, 32'hFFFF_FFFF, 32'd10, {32'd5, 32'h1999_9999}, 1'b1);
        wait_cyc(4);
        drive_start(2'b00, 32'd5, 32'd5, 64'd0, 1'b0);
        wait_cyc(70);

        // Reset in the middle of an operation.
        drive_start(2'b00, 32'hFFFF_FFFF, 32'h1234_5678, 64'd0, 1'b0);
        wait_cyc(9);
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        check("midop_reset_lo", 64'(lo), 64'd0);
        #2;
        rst_n = 1'b1;
        wait_cyc(1);
        check("midop_reset_idle", 64'(busy), 64'd0);
        wait_cyc(40);

        // Randomized operations; gap 0 restarts in the done cycle.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = rand_opnd();
            rb = rand_opnd();
            drive_start(ro, ra, rb, model(ro, ra, rb), 1'b1);
            wait_cyc(33 + $urandom_range(0, 3));
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) wait_cyc(1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Sequential multiply/divide engine that writes its 64-bit result into architectural HI/LO registers for the MIPS pipeline.
- The EX stage issues an operation with a start pulse and stalls on busy.
- mfhi/mflo read the hi/lo outputs directly; mthi/mtlo write HI or LO individually.
- Replaces single-cycle mul/div in the EX path with a 32-iteration radix-2 datapath: shift-add for multiply, restoring division for divide.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 multu, 01 mult (signed), 10 divu, 11 div (signed).
- src_a  in  WIDTH  multiplicand or dividend; captured at start.
- src_b  in  WIDTH  multiplier or divisor; captured at start.
- flush  in  1  abort the in-flight operation (pipeline flush).
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  high while state != IDLE.
- done  out  1  registered one-cycle pulse; hi/lo are valid in the same cycle.
- hi  out  WIDTH  HI register (product high word / remainder).
- lo  out  WIDTH  LO register (product low word / quotient).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - busy=0, done=0, hi=0, lo=0.
  - All internal operand and accumulator registers cleared.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1: capture op, src_a, src_b. Signed ops store operand magnitudes plus a result-sign flag (and a dividend-sign flag for div). Go to CALC with counter=0.
  - No start: hi_we loads hi<=wdata; lo_we loads lo<=wdata. Both may be asserted in the same cycle.
- CALC: one iteration per cycle for WIDTH cycles; counter increments; at counter==WIDTH-1, go to FIX.
  - Multiply: if multiplier LSB is set, add the multiplicand to the upper accumulator; shift the accumulator right one bit.
  - Divide: shift {rem, quot} left; trial-subtract the divisor; if non-negative, keep the difference and set the quot LSB.
- FIX:
  - Apply sign correction: two's-complement negate the 64-bit product, or negate the quotient and/or remainder.
  - Write hi/lo, set done for the next cycle, go to IDLE.
- Latency: start sampled at cycle 0 -> busy high in cycles 1..WIDTH+1 -> done=1 with hi/lo updated in cycle WIDTH+2 (34 for WIDTH=32).
- Signed divide rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (div or divu): lo=all ones, hi=src_a unchanged; sign fixup is skipped; latency unchanged.
- Boundary and priority conditions:
  - start while busy: ignored; no queuing.
  - start in the same cycle as done: accepted, since state is already IDLE.
  - start with hi_we/lo_we in IDLE: start wins; the writes are dropped.
  - hi_we/lo_we while busy: ignored.
  - flush in CALC or FIX: state -> IDLE next cycle; hi/lo unchanged; no done pulse. flush in IDLE has no effect, and start in the same cycle as flush is ignored.
  - Reset mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: during multiply CALC, if the remaining unshifted multiplier bits are all zero, jump to FIX and pre-align the accumulator by the remaining shift count. Latency becomes variable, at minimum 3 cycles to done. Divide is unaffected.
- Not defined: every operation takes the fixed WIDTH+2 cycles to done.

Test Plan:
- multu FFFFFFFF x FFFFFFFF -> done at cycle 34; hi=FFFFFFFE, lo=00000001; busy high in cycles 1..33.
- mult FFFFFFFD(-3) x 00000005 -> hi=FFFFFFFF, lo=FFFFFFF1. div FFFFFFF9(-7) / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
- divu 00001234 / 0 -> lo=FFFFFFFF, hi=00001234, done at cycle 34. div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- hi_we=1, wdata=AAAA0000 in IDLE -> hi=AAAA0000. Start multu, assert flush at cycle 10 -> busy=0 at cycle 11, no done, hi still AAAA0000.
- Back-to-back: a second start in the done cycle is accepted and its done lands 34 cycles later. A start at cycle 5 while busy is ignored; the first result is unaffected.
- With MULDIV_EARLY_OUT_EN: multu 00000007 x 00000003 -> lo=00000015, hi=0, done well before cycle 34. Without the macro -> same values at cycle 34.
